// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS control FSM: opcodes, state
// encodings, ALU-op codes and the decoded control vector.
// Optional feature macro: MULTICYCLE_CONTROL_BNE_EN (adds bne support).
`ifndef MULTICYCLE_CONTROL_PKG_SV
`define MULTICYCLE_CONTROL_PKG_SV

package multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
`ifdef MULTICYCLE_CONTROL_BNE_EN
    ,
    S_BNEEX   = 4'd12
`endif
  } state_t;

  // Moore control vector decoded from the state alone.
  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
`ifdef MULTICYCLE_CONTROL_BNE_EN
    logic       branch_ne;
`endif
  } ctrl_t;

endpackage

`endif

// File: rtl/multicycle_control_outdec.sv
// Combinational state -> control-vector decoder for the multicycle control FSM.
// Optional feature macro: MULTICYCLE_CONTROL_BNE_EN (decodes BNEEX).
module multicycle_control_outdec
  import multicycle_control_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  // Decode each state into its control vector; anything not listed stays 0.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req = 1'b1;
        ctrl.alusrcb = 2'b01;
        ctrl.aluop   = ALUOP_ADD;
        // Gated with mem_ready in the top.
        ctrl.irwrite = 1'b1;
        ctrl.pcwrite = 1'b1;
      end
      S_DECODE: begin
        ctrl.alusrcb = 2'b11;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_req  = 1'b1;
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_BEQEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = 2'b01;
        ctrl.branch  = 1'b1;
      end
      S_ADDIWB: begin
        ctrl.regwrite = 1'b1;
      end
      S_JEX: begin
        ctrl.pcsrc   = 2'b10;
        ctrl.pcwrite = 1'b1;
      end
`ifdef MULTICYCLE_CONTROL_BNE_EN
      S_BNEEX: begin
        ctrl.alusrca   = 1'b1;
        ctrl.aluop     = ALUOP_SUB;
        ctrl.pcsrc     = 2'b01;
        ctrl.branch_ne = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: state register,
// next-state logic, FETCH handshake gating, pcen and reset output gating.
// Optional feature macro: MULTICYCLE_CONTROL_BNE_EN (adds bne / BNEEX).
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       bad_op,
  output logic [3:0] state
);

  state_t state_q, state_d;
  ctrl_t  ctrl;
  logic   mem_ok;
  logic   op_bad;
  logic   pcwrite;

  assign mem_ok = MEM_HANDSHAKE ? mem_ready : 1'b1;

  multicycle_control_outdec u_outdec (
    .state (state_q),
    .ctrl  (ctrl)
  );

  // State register with synchronous reset to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; op is only looked at in DECODE and MEMADR.
  always_comb begin
    state_d = S_FETCH;
    op_bad  = 1'b0;
    case (state_q)
      S_FETCH:   state_d = mem_ok ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
`ifdef MULTICYCLE_CONTROL_BNE_EN
          OP_BNE:       state_d = S_BNEEX;
`endif
          default:      op_bad  = 1'b1;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = mem_ok ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = mem_ok ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // Only the FETCH strobes wait on memory; the JEX pcwrite is unconditional.
  assign pcwrite = ctrl.pcwrite & ((state_q != S_FETCH) | mem_ok);

  // Drive outputs, forcing everything to 0 while reset is asserted.
  always_comb begin
    mem_req  = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    aluop    = 2'b00;
    pcsrc    = 2'b00;
    pcen     = 1'b0;
    bad_op   = 1'b0;
    state    = 4'd0;
    if (!reset) begin
      mem_req  = ctrl.mem_req;
      iord     = ctrl.iord;
      memwrite = ctrl.memwrite;
      irwrite  = ctrl.irwrite & mem_ok;
      regdst   = ctrl.regdst;
      memtoreg = ctrl.memtoreg;
      regwrite = ctrl.regwrite;
      alusrca  = ctrl.alusrca;
      alusrcb  = ctrl.alusrcb;
      aluop    = ctrl.aluop;
      pcsrc    = ctrl.pcsrc;
`ifdef MULTICYCLE_CONTROL_BNE_EN
      pcen     = pcwrite | (ctrl.branch & zero) | (ctrl.branch_ne & ~zero);
`else
      pcen     = pcwrite | (ctrl.branch & zero);
`endif
      bad_op   = op_bad;
      state    = state_q;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: a vector table, hand-written
// corner sequences, and random stimulus against an instruction-level model.
module tb_multicycle_control;

`ifdef MULTICYCLE_CONTROL_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  // Phase numbers equal the externally visible state codes.
  localparam int P_F = 0, P_D = 1, P_A = 2, P_RD = 3, P_MWB = 4, P_WR = 5, P_RX = 6;
  localparam int P_RW = 7, P_BX = 8, P_AX = 9, P_AW = 10, P_JX = 11, P_BNX = 12;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       bad_op;
    logic [3:0] state;
  } ov_t;

  typedef struct {
    logic       r;
    logic [5:0] op;
    logic       mr;
    logic       z;
    ov_t        e;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic       pcen, bad_op;
  logic [3:0] state;
  ov_t        act;

  int errors = 0;
  int checks = 0;

  // Model: current phase plus the remaining phases of the instruction.
  int cur = P_F;
  int rest[$];

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .iord      (iord),
    .memwrite  (memwrite),
    .irwrite   (irwrite),
    .regdst    (regdst),
    .memtoreg  (memtoreg),
    .regwrite  (regwrite),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .aluop     (aluop),
    .pcsrc     (pcsrc),
    .pcen      (pcen),
    .bad_op    (bad_op),
    .state     (state)
  );

  assign act = {mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, aluop, pcsrc, pcen, bad_op, state};

  function automatic ov_t ov(input logic [3:0] st, input logic mq, input logic io,
                             input logic mw, input logic irw, input logic rd, input logic mtr,
                             input logic rw, input logic asa, input logic [1:0] asb,
                             input logic [1:0] aop, input logic [1:0] pcs, input logic pe,
                             input logic bad);
    return {mq, io, mw, irw, rd, mtr, rw, asa, asb, aop, pcs, pe, bad, st};
  endfunction

  function automatic bit supported(input logic [5:0] o);
    case (o)
      6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02: return 1'b1;
      6'h05:   return BNE_EN;
      default: return 1'b0;
    endcase
  endfunction

  function automatic ov_t expect_out(input int ph, input logic r, input logic [5:0] o,
                                     input logic mr, input logic z);
    ov_t e;
    e = '0;
    if (r) return e;
    e.state = 4'(ph);
    case (ph)
      P_F:   begin e.mem_req = 1; e.alusrcb = 2'b01; e.irwrite = mr; e.pcen = mr; end
      P_D:   begin e.alusrcb = 2'b11; e.bad_op = !supported(o); end
      P_A:   begin e.alusrca = 1; e.alusrcb = 2'b10; end
      P_RD:  begin e.mem_req = 1; e.iord = 1; end
      P_MWB: begin e.memtoreg = 1; e.regwrite = 1; end
      P_WR:  begin e.mem_req = 1; e.iord = 1; e.memwrite = 1; end
      P_RX:  begin e.alusrca = 1; e.aluop = 2'b10; end
      P_RW:  begin e.regdst = 1; e.regwrite = 1; end
      P_BX:  begin e.alusrca = 1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.pcen = z; end
      P_AX:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
      P_AW:  begin e.regwrite = 1; end
      P_JX:  begin e.pcsrc = 2'b10; e.pcen = 1; end
      P_BNX: begin e.alusrca = 1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.pcen = !z; end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic model_advance(input logic r, input logic [5:0] o, input logic mr);
    if (r) begin
      cur = P_F;
      rest.delete();
    end else if ((cur == P_F || cur == P_RD || cur == P_WR) && !mr) begin
      cur = cur;
    end else if (cur == P_F) begin
      cur = P_D;
      rest.delete();
    end else begin
      if (cur == P_D) begin
        rest.delete();
        case (o)
          6'h23: begin rest.push_back(P_A); rest.push_back(P_RD); rest.push_back(P_MWB); end
          6'h2b: begin rest.push_back(P_A); rest.push_back(P_WR); end
          6'h00: begin rest.push_back(P_RX); rest.push_back(P_RW); end
          6'h04: rest.push_back(P_BX);
          6'h08: begin rest.push_back(P_AX); rest.push_back(P_AW); end
          6'h02: rest.push_back(P_JX);
          6'h05: if (BNE_EN) rest.push_back(P_BNX);
          default: ;
        endcase
      end
      cur = (rest.size() > 0) ? rest.pop_front() : P_F;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, sample 1ns later, check model, advance.
  task automatic step(input logic r, input logic [5:0] o, input logic mr, input logic z,
                      output ov_t got);
    @(negedge clk);
    reset = r;
    op = o;
    mem_ready = mr;
    zero = z;
    #1;
    got = act;
    chk("model", 32'(got), 32'(expect_out(cur, r, o, mr, z)));
    model_advance(r, o, mr);
  endtask

  vec_t tbl[28];

  initial begin
    ov_t g;
    ov_t e_f1, e_f0, e_d, e_dbad, e_a, e_rd, e_mwb;
    logic [5:0] ops[8];
    logic [5:0] o;
    logic r, mr, z;

    e_f1   = ov(4'd0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 0);
    e_f0   = ov(4'd0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0);
    e_d    = ov(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0);
    e_dbad = ov(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 1);
    e_a    = ov(4'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0);
    e_rd   = ov(4'd3, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    e_mwb  = ov(4'd4, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0);

    tbl[0]  = '{1'b1, 6'h23, 1'b1, 1'b0, ov_t'('0)};
    tbl[1]  = '{1'b0, 6'h23, 1'b1, 1'b0, e_f1};
    tbl[2]  = '{1'b0, 6'h23, 1'b1, 1'b0, e_d};
    tbl[3]  = '{1'b0, 6'h23, 1'b1, 1'b0, e_a};
    tbl[4]  = '{1'b0, 6'h23, 1'b1, 1'b0, e_rd};
    tbl[5]  = '{1'b0, 6'h23, 1'b1, 1'b0, e_mwb};
    tbl[6]  = '{1'b0, 6'h04, 1'b1, 1'b1, e_f1};
    tbl[7]  = '{1'b0, 6'h04, 1'b1, 1'b1, e_d};
    tbl[8]  = '{1'b0, 6'h04, 1'b1, 1'b1,
                ov(4'd8, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 1, 0)};
    tbl[9]  = '{1'b0, 6'h04, 1'b1, 1'b0, e_f1};
    tbl[10] = '{1'b0, 6'h04, 1'b1, 1'b0, e_d};
    tbl[11] = '{1'b0, 6'h04, 1'b1, 1'b0,
                ov(4'd8, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0, 0)};
    tbl[12] = '{1'b0, 6'h3f, 1'b1, 1'b0, e_f1};
    tbl[13] = '{1'b0, 6'h3f, 1'b1, 1'b0, e_dbad};
    tbl[14] = '{1'b0, 6'h00, 1'b0, 1'b0, e_f0};
    tbl[15] = '{1'b0, 6'h00, 1'b0, 1'b1, e_f0};
    tbl[16] = '{1'b0, 6'h00, 1'b1, 1'b0, e_f1};
    tbl[17] = '{1'b0, 6'h00, 1'b1, 1'b0, e_d};
    tbl[18] = '{1'b0, 6'h00, 1'b1, 1'b0,
                ov(4'd6, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0)};
    tbl[19] = '{1'b0, 6'h00, 1'b1, 1'b0,
                ov(4'd7, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0)};
    tbl[20] = '{1'b0, 6'h08, 1'b1, 1'b0, e_f1};
    tbl[21] = '{1'b0, 6'h08, 1'b1, 1'b0, e_d};
    tbl[22] = '{1'b0, 6'h08, 1'b1, 1'b0,
                ov(4'd9, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0)};
    tbl[23] = '{1'b0, 6'h08, 1'b1, 1'b0,
                ov(4'd10, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0)};
    tbl[24] = '{1'b0, 6'h02, 1'b1, 1'b0, e_f1};
    tbl[25] = '{1'b0, 6'h02, 1'b1, 1'b0, e_d};
    tbl[26] = '{1'b0, 6'h02, 1'b1, 1'b0,
                ov(4'd11, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 1, 0)};
    tbl[27] = '{1'b0, 6'h02, 1'b1, 1'b0, e_f1};

    for (int i = 0; i < 28; i++) begin
      step(tbl[i].r, tbl[i].op, tbl[i].mr, tbl[i].z, g);
      chk($sformatf("table[%0d]", i), 32'(g), 32'(tbl[i].e));
    end

    // sw with three wait cycles in MEMWR, then FETCH holding on mem_ready=0.
    step(1'b1, 6'h2b, 1'b1, 1'b0, g);
    step(1'b0, 6'h2b, 1'b1, 1'b0, g);
    step(1'b0, 6'h2b, 1'b1, 1'b0, g);
    step(1'b0, 6'h2b, 1'b1, 1'b0, g);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 6'h2b, (i == 3), 1'b0, g);
      chk("sw_memwrite", 32'({g.memwrite, g.state}), 32'({1'b1, 4'd5}));
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 6'h2b, 1'b0, 1'b0, g);
      chk("fetch_wait", 32'({g.state, g.irwrite, g.pcen, g.mem_req}), 32'({4'd0, 3'b001}));
    end

    // Reset held two cycles in the middle of MEMRD.
    step(1'b0, 6'h23, 1'b1, 1'b0, g);
    step(1'b0, 6'h23, 1'b1, 1'b0, g);
    step(1'b0, 6'h23, 1'b1, 1'b0, g);
    step(1'b0, 6'h23, 1'b0, 1'b0, g);
    chk("memrd_wait", 32'(g.state), 32'd3);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 6'h23, 1'b1, 1'b1, g);
      chk("reset_zero", 32'(g), 32'd0);
    end
    step(1'b0, 6'h23, 1'b1, 1'b0, g);
    chk("post_reset", 32'({g.state, g.mem_req}), 32'({4'd0, 1'b1}));

    // Opcode 6'h05: unsupported unless bne is built in.
    step(1'b1, 6'h05, 1'b1, 1'b0, g);
    step(1'b0, 6'h05, 1'b1, 1'b0, g);
    step(1'b0, 6'h05, 1'b1, 1'b0, g);
    chk("op05_bad", 32'(g.bad_op), 32'(!BNE_EN));
    step(1'b0, 6'h05, 1'b1, 1'b0, g);
    chk("op05_next", 32'({g.state, g.pcen}), BNE_EN ? 32'({4'd12, 1'b1}) : 32'({4'd0, 1'b1}));

    // Random instruction mix against the model.
    ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02, 6'h05, 6'h3f};
    o = 6'h00;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 63) == 0);
      if (cur == P_F) begin
        o = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
      end
      mr = ($urandom_range(0, 3) != 0);
      z = 1'($urandom);
      step(r, o, mr, z, g);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM of the multicycle MIPS datapath.
- Sequences every instruction through fetch, decode, execute, memory and writeback.
- Drives all datapath mux selects and write enables.
- Produces aluop, which the downstream ALU-control decoder combines with funct to generate the 4-bit ALU operation.

Parameters:
- MEM_HANDSHAKE, 1: 1 = FETCH/MEMRD/MEMWR wait for mem_ready; 0 = mem_ready ignored, treated as 1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- op  in  6  opcode, instr[31:26] from IR
- zero  in  1  ALU zero flag; passed through only via pcen
- mem_ready  in  1  memory has completed the current access this cycle
- mem_req  out  1  memory access request
- iord  out  1  0 = PC address, 1 = ALUOut address
- memwrite  out  1  memory write strobe
- irwrite  out  1  IR load enable
- regdst  out  1  0 = rt, 1 = rd
- memtoreg  out  1  0 = ALUOut, 1 = MDR
- regwrite  out  1  register file write enable
- alusrca  out  1  0 = PC, 1 = A
- alusrcb  out  2  00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2
- aluop  out  2  00 = add, 01 = sub, 10 = funct-decoded
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- pcen  out  1  PC load enable = pcwrite | (branch & zero), branch_ne term when enabled
- bad_op  out  1  unsupported opcode seen in DECODE
- state  out  4  current state, debug

Behaviour:
- Opcodes: R-type 6'h00, lw 6'h23, sw 6'h2b, beq 6'h04, addi 6'h08, j 6'h02.
- Registered 4-bit state; all outputs Moore (decoded from state), except FETCH gating by mem_ready.
- Synchronous reset: reset high at a clk edge loads FETCH. While reset is high, every output is forced to 0, including state output = FETCH encoding 0.
- Any output not listed for a state is 0.
- FETCH:
  - mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite=pcwrite=mem_ready.
  - Stay in FETCH until mem_ready, then go to DECODE.
- DECODE:
  - alusrcb=11, aluop=00 (branch target precompute).
  - lw/sw -> MEMADR; R -> RTYPEEX; beq -> BEQEX; addi -> ADDIEX; j -> JEX.
  - Any other opcode -> FETCH with bad_op=1 for this cycle only. No register or memory write occurs.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. lw -> MEMRD; sw -> MEMWR.
- MEMRD: mem_req=1, iord=1. Hold until mem_ready, then -> MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
- MEMWR:
  - mem_req=1, iord=1, memwrite=1, held every cycle until mem_ready.
  - Then -> FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10 -> RTYPEWB.
- RTYPEWB: regdst=1, regwrite=1 -> FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1 -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00 -> ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
- JEX: pcsrc=10, pcwrite=1 -> FETCH.
- Cycle counts with mem_ready held high:
  - lw = 5, sw = 4, R = 4, addi = 4, beq = 3, j = 3.
- Each memory wait cycle adds 1.
- Unused state encodings -> FETCH next cycle, outputs 0.
- Reset mid-instruction: next state is FETCH. Any strobe in that cycle is suppressed by the reset gating.
- op is sampled only in DECODE and MEMADR; the IR is held stable by irwrite=0.

Optional Feature:
- Macro: MULTICYCLE_CONTROL_BNE_EN.
- Defined:
  - opcode 6'h05 in DECODE -> BNEEX, with the same outputs as BEQEX except branch=0 and branch_ne=1.
  - pcen = pcwrite | (branch & zero) | (branch_ne & ~zero).
- Undefined: 6'h05 is unsupported and raises bad_op; no BNEEX state is encoded.

Decomposition:
- Shared include file, guarded like other shared headers, holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_BNE);
  - state encodings (S_FETCH=0 ... S_JEX, S_BNEEX);
  - aluop constants (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10).
- One natural sub-module: multicycle_control_outdec, the purely combinational state -> control-vector decoder. The top module holds only the state register, next-state logic and pcen.

Test Plan:
- Reset held 2 cycles mid-MEMRD, then released -> all outputs 0 during reset; state=FETCH, mem_req=1 first cycle after release.
- op=6'h23 with mem_ready=1 always -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB. regwrite=1, memtoreg=1 only in cycle 5; back to FETCH.
- op=6'h2b, mem_ready low for 3 cycles in MEMWR -> memwrite=1 for 4 consecutive cycles, then FETCH. In FETCH with mem_ready=0, irwrite=pcwrite=0 and the state holds.
- op=6'h00 -> aluop=10 exactly in RTYPEEX; next cycle regdst=1, regwrite=1.
- op=6'h04 with zero=1 -> pcen=1, pcsrc=01 in BEQEX. Repeat with zero=0 -> pcen=0.
- op=6'h3f -> bad_op=1 in DECODE for one cycle, then FETCH, no write strobes. op=6'h05 -> bad_op only when the macro is undefined; with the macro defined, pcen follows ~zero.
